// File: rtl/transform_pkg.sv
// Shared constants for the inverse-scan buffer: block types, block lengths,
// scan-to-raster tables and block classification.
package transform_pkg;

  localparam logic [2:0] BT_I16_AC    = 3'd2;
  localparam logic [2:0] BT_CHROMA_DC = 3'd5;
  localparam logic [2:0] BT_CHROMA_AC = 3'd6;

  localparam logic [4:0] LEN_FULL = 5'd16;
  localparam logic [4:0] LEN_AC   = 5'd15;
  localparam logic [4:0] LEN_CDC  = 5'd4;

  localparam logic [3:0] FRAME_ZZ [16] = '{
    4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
    4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15
  };

  localparam logic [3:0] FIELD_SCAN [16] = '{
    4'd0, 4'd4, 4'd1, 4'd8, 4'd12, 4'd5, 4'd9, 4'd13,
    4'd2, 4'd6, 4'd10, 4'd14, 4'd3, 4'd7, 4'd11, 4'd15
  };

  typedef enum logic {BANK_EMPTY = 1'b0, BANK_FULL = 1'b1} bank_state_t;
  typedef enum logic [1:0] {CLS_FULL = 2'd0, CLS_AC = 2'd1, CLS_CDC = 2'd2} blk_class_t;

  function automatic blk_class_t classify(input logic [2:0] bt);
    if (bt == BT_I16_AC || bt == BT_CHROMA_AC) return CLS_AC;
    if (bt == BT_CHROMA_DC) return CLS_CDC;
    return CLS_FULL;
  endfunction

  function automatic logic [4:0] blk_len(input blk_class_t cls);
    case (cls)
      CLS_AC:  return LEN_AC;
      CLS_CDC: return LEN_CDC;
      default: return LEN_FULL;
    endcase
  endfunction

endpackage

// File: rtl/inverse_scan_lut.sv
// Combinational scan-index to raster-index lookup for frame zigzag and field scan.
module inverse_scan_lut
  import transform_pkg::*;
(
  input  logic       field_scan,
  input  logic [3:0] scan_idx,
  output logic [3:0] raster_idx
);

  assign raster_idx = field_scan ? FIELD_SCAN[scan_idx] : FRAME_ZZ[scan_idx];

endmodule

// File: rtl/transform_inverse_scan_buffer.sv
// Ping-pong inverse-scan buffer: loads coefficients in scan order into raster
// positions and drains each finished block as column beats.
module transform_inverse_scan_buffer
  import transform_pkg::*;
#(
  parameter int COEFF_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2:0]                blk_type,
  input  logic                      field_scan,
  input  logic signed [COEFF_W-1:0] dc_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [COEFF_W-1:0] in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [1:0]                out_col,
  output logic                      out_last,
  output logic [2:0]                out_blk_type,
  output logic signed [COEFF_W-1:0] out_0,
  output logic signed [COEFF_W-1:0] out_1,
  output logic signed [COEFF_W-1:0] out_2,
  output logic signed [COEFF_W-1:0] out_3
);

  logic                      wr_bank;
  logic                      rd_bank;
  bank_state_t               state [2];
  logic [2:0]                btype [2];
  logic                      field_q;
  logic [3:0]                cnt;
  logic [1:0]                col;
  logic signed [COEFF_W-1:0] mem [2][16];

  logic       accept;
  logic       first;
  logic [2:0] cur_type;
  logic       cur_field;
  blk_class_t cur_cls;
  logic [3:0] scan_idx;
  logic [3:0] lut_idx;
  logic [3:0] wr_idx;
  logic       close;
  logic       out_fire;
  logic       rd_is_cdc;

  // Load side: the block's attributes come from the inputs on its first beat
  assign in_ready  = (state[wr_bank] == BANK_EMPTY);
  assign accept    = in_valid && in_ready;
  assign first     = (cnt == 4'd0);
  assign cur_type  = first ? blk_type : btype[wr_bank];
  assign cur_field = first ? field_scan : field_q;
  assign cur_cls   = classify(cur_type);
  assign scan_idx  = (cur_cls == CLS_AC) ? cnt + 4'd1 : cnt;
  assign wr_idx    = (cur_cls == CLS_CDC) ? cnt : lut_idx;
  assign close     = accept && (in_last || ({1'b0, cnt} + 5'd1 == blk_len(cur_cls)));

  inverse_scan_lut u_lut (
    .field_scan (cur_field),
    .scan_idx   (scan_idx),
    .raster_idx (lut_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      field_q <= 1'b0;
      cnt     <= 4'd0;
      col     <= 2'd0;
      for (int b = 0; b < 2; b++) begin
        state[b] <= BANK_EMPTY;
        btype[b] <= 3'd0;
      end
    end else begin
      if (accept) begin
        if (first) begin
          btype[wr_bank] <= blk_type;
          field_q        <= field_scan;
        end
        cnt <= close ? 4'd0 : cnt + 4'd1;
        if (close) begin
          state[wr_bank] <= BANK_FULL;
          wr_bank        <= ~wr_bank;
        end
      end
      // The draining bank is always the other one while a load is accepted
      if (out_fire) begin
        if (out_last) begin
          state[rd_bank] <= BANK_EMPTY;
          rd_bank        <= ~rd_bank;
          col            <= 2'd0;
        end else begin
          col <= col + 2'd1;
        end
      end
    end
  end

  // Coefficient storage is data only; a first beat clears stale contents
  always_ff @(posedge clk) begin
    if (accept) begin
      if (first) begin
        for (int i = 0; i < 16; i++) begin
          mem[wr_bank][i] <= (i == 0 && cur_cls == CLS_AC) ? dc_in : '0;
        end
      end
      mem[wr_bank][wr_idx] <= in_data;
    end
  end

  // Drain side
  assign out_valid = (state[rd_bank] == BANK_FULL);
  assign out_fire  = out_valid && out_ready;
  assign rd_is_cdc = (classify(btype[rd_bank]) == CLS_CDC);
  assign out_col   = col;
  assign out_last  = out_valid && (rd_is_cdc || col == 2'd3);

  always_comb begin
    out_blk_type = 3'd0;
    out_0        = '0;
    out_1        = '0;
    out_2        = '0;
    out_3        = '0;
    if (out_valid) begin
      out_blk_type = btype[rd_bank];
      if (rd_is_cdc) begin
        out_0 = mem[rd_bank][0];
        out_1 = mem[rd_bank][1];
        out_2 = mem[rd_bank][2];
        out_3 = mem[rd_bank][3];
      end else begin
        out_0 = mem[rd_bank][{2'd0, col}];
        out_1 = mem[rd_bank][{2'd1, col}];
        out_2 = mem[rd_bank][{2'd2, col}];
        out_3 = mem[rd_bank][{2'd3, col}];
      end
    end
  end

endmodule

// File: tb/tb_transform_inverse_scan_buffer.sv
// Directed bench for transform_inverse_scan_buffer with hand-computed raster tables.
module tb_transform_inverse_scan_buffer;

  localparam int W = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [2:0]          blk_type = 3'd0;
  logic                field_scan = 1'b0;
  logic signed [W-1:0] dc_in = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] in_data = '0;
  logic                in_last = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [1:0]          out_col;
  logic                out_last;
  logic [2:0]          out_blk_type;
  logic signed [W-1:0] out_0, out_1, out_2, out_3;

  int n_checks = 0;
  int n_errors = 0;

  // Raster contents (index row*4+col) when beat s carries value s+1
  int frame_r [16] = '{1, 2, 6, 7, 3, 5, 8, 13, 4, 9, 12, 14, 10, 11, 15, 16};
  int field_r [16] = '{1, 3, 9, 13, 2, 6, 10, 14, 4, 7, 11, 15, 5, 8, 12, 16};
  int ac1_r   [16] = '{100, 7, 0, 0, 8, 0, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0};
  int ac2_r   [16] = '{-5, 42, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int ac3_r   [16] = '{7, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int ac4_r   [16] = '{9, 4, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  transform_inverse_scan_buffer #(.COEFF_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .blk_type     (blk_type),
    .field_scan   (field_scan),
    .dc_in        (dc_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_col      (out_col),
    .out_last     (out_last),
    .out_blk_type (out_blk_type),
    .out_0        (out_0),
    .out_1        (out_1),
    .out_2        (out_2),
    .out_3        (out_3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance
  task automatic send(input logic [2:0] bt, input logic fs, input int dc, input int data,
                      input logic last);
    int waited = 0;
    blk_type   = bt;
    field_scan = fs;
    dc_in      = W'(dc);
    in_data    = W'(data);
    in_last    = last;
    in_valid   = 1'b1;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) chk("send_ready", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_full(input logic [2:0] bt, input logic fs, input int base);
    for (int i = 0; i < 16; i++) send(bt, fs, 0, base + i + 1, 1'b0);
  endtask

  task automatic expect_beat(input string tag, input int col, input int v0, input int v1,
                             input int v2, input int v3, input int last, input int bt);
    int waited = 0;
    while (!out_valid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, ".valid"}, int'(out_valid), 1);
    chk({tag, ".col"}, int'(out_col), col);
    chk({tag, ".r0"}, int'(out_0), v0);
    chk({tag, ".r1"}, int'(out_1), v1);
    chk({tag, ".r2"}, int'(out_2), v2);
    chk({tag, ".r3"}, int'(out_3), v3);
    chk({tag, ".last"}, int'(out_last), last);
    chk({tag, ".type"}, int'(out_blk_type), bt);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic drain4(input string tag, input int r [16], input int off, input int bt);
    for (int c = 0; c < 4; c++) begin
      expect_beat($sformatf("%s.c%0d", tag, c), c, r[c] + off, r[4 + c] + off,
                  r[8 + c] + off, r[12 + c] + off, (c == 3) ? 1 : 0, bt);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".in_ready"}, int'(in_ready), 1);
    chk({tag, ".out_valid"}, int'(out_valid), 0);
    chk({tag, ".out_col"}, int'(out_col), 0);
    chk({tag, ".out_last"}, int'(out_last), 0);
    chk({tag, ".out_type"}, int'(out_blk_type), 0);
    chk({tag, ".out_0"}, int'(out_0), 0);
    chk({tag, ".out_3"}, int'(out_3), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Full block, frame zigzag
    send_full(3'd0, 1'b0, 0);
    chk("t1.latency", int'(out_valid), 1);
    drain4("t1", frame_r, 0, 0);
    chk("t1.empty", int'(out_valid), 0);

    // AC block ending after three beats
    send(3'd2, 1'b0, 100, 7, 1'b0);
    send(3'd2, 1'b0, 100, 8, 1'b0);
    send(3'd2, 1'b0, 100, 9, 1'b1);
    drain4("t2", ac1_r, 0, 2);

    // Chroma DC: single beat
    send(3'd5, 1'b1, 0, -1, 1'b0);
    send(3'd5, 1'b1, 0, 2, 1'b0);
    send(3'd5, 1'b1, 0, -3, 1'b0);
    send(3'd5, 1'b1, 0, 4, 1'b0);
    expect_beat("t3", 0, -1, 2, -3, 4, 1, 5);
    chk("t3.empty", int'(out_valid), 0);

    // Field scan
    send_full(3'd0, 1'b1, 0);
    drain4("t4", field_r, 0, 0);

    // Chroma AC closed on its first beat
    send(3'd6, 1'b0, -5, 42, 1'b1);
    drain4("t4b", ac2_r, 0, 6);

    // Backpressure and ping-pong
    send_full(3'd0, 1'b0, 0);
    chk("t5.in_ready_after16", int'(in_ready), 1);
    send_full(3'd3, 1'b0, 100);
    chk("t5.in_ready_after32", int'(in_ready), 0);
    blk_type = 3'd0;
    in_data  = 16'sd999;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || out_col !== 2'd0 || out_0 !== 16'sd1 || out_1 !== 16'sd3 ||
          out_2 !== 16'sd4 || out_3 !== 16'sd10 || in_ready !== 1'b0)
        bad++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("t5.hold_bad_cycles", bad, 0);
    for (int c = 0; c < 3; c++) begin
      expect_beat($sformatf("t5.b1.c%0d", c), c, frame_r[c], frame_r[4 + c],
                  frame_r[8 + c], frame_r[12 + c], 0, 0);
    end
    chk("t5.in_ready_before_last", int'(in_ready), 0);
    expect_beat("t5.b1.c3", 3, frame_r[3], frame_r[7], frame_r[11], frame_r[15], 1, 0);
    chk("t5.in_ready_after_last", int'(in_ready), 1);
    drain4("t5.b2", frame_r, 100, 3);
    send_full(3'd0, 1'b0, 200);
    drain4("t5.b3", frame_r, 200, 0);

    // Reset while one bank is full and the other partially loaded
    send_full(3'd0, 1'b0, 0);
    for (int i = 0; i < 5; i++) send(3'd0, 1'b0, 0, 51 + i, 1'b0);
    chk("t6.pre_valid", int'(out_valid), 1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("t6.rst");
    @(negedge clk);
    rst = 1'b0;
    send(3'd2, 1'b0, 7, 3, 1'b1);
    drain4("t6.a", ac3_r, 0, 2);
    send(3'd6, 1'b0, 9, 4, 1'b0);
    send(3'd6, 1'b0, 9, 5, 1'b1);
    drain4("t6.b", ac4_r, 0, 6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
